ippcrc_crc12_acc56: RTL

Sequential CRC-12 accumulator for 56-bit datapath frames in the ippcrc package. It accepts a framed stream of 56-bit words, runs each word through the combinational CRC-12/56-bit core, and holds the running remainder between words. At end of frame it presents the final CRC to the downstream consumer through a valid/ready result port. It sits directly upstream of the combinational core: it supplies `ci`/`di` and registers `co`.

---
 rtl/ippcrc_pkg.sv | 17 +
 rtl/ippcrc_crc12_56b.sv | 25 ++
 rtl/ippcrc_crc12_acc56.sv | 110 +++++++++++
 3 files changed

// File: rtl/ippcrc_pkg.sv
// Shared types and constants for the ippcrc CRC-12 / 56-bit datapath blocks.
// Holds the accumulator FSM state encoding and the default CRC parameters.
package ippcrc_pkg;

    localparam int unsigned CRC12_W = 12;
    localparam int unsigned DAT56_W = 56;

    localparam logic [CRC12_W-1:0] CRC12_POLY     = 12'h80F;
    localparam logic [CRC12_W-1:0] CRC_INIT_DEF   = 12'h000;
    localparam logic [CRC12_W-1:0] CRC_XOROUT_DEF = 12'h000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/ippcrc_crc12_56b.sv
// Combinational CRC-12 (poly 0x80F, MSB-first register) over one 56-bit word.
// di[0] is shifted in first; co is the remainder after all 56 bits.
module ippcrc_crc12_56b
    import ippcrc_pkg::*;
(
    input  logic [CRC12_W-1:0] ci,
    input  logic [DAT56_W-1:0] di,
    output logic [CRC12_W-1:0] co
);

    logic [CRC12_W-1:0] w_r;

    always_comb begin
        w_r = ci;
        for (int k = 0; k < DAT56_W; k++) begin
            if (w_r[CRC12_W-1] ^ di[k]) begin
                w_r = {w_r[CRC12_W-2:0], 1'b0} ^ CRC12_POLY;
            end else begin
                w_r = {w_r[CRC12_W-2:0], 1'b0};
            end
        end
        co = w_r;
    end

endmodule

// File: rtl/ippcrc_crc12_acc56.sv
// Framed CRC-12 accumulator over 56-bit words with a valid/ready result port.
// Define IPPCRC_CRC12_CHK_EN to add i_crc_exp / o_crc_err result checking.
module ippcrc_crc12_acc56
    import ippcrc_pkg::*;
#(
    parameter logic [CRC12_W-1:0] CRC_INIT   = CRC_INIT_DEF,
    parameter logic [CRC12_W-1:0] CRC_XOROUT = CRC_XOROUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_vld,
    input  logic               i_sop,
    input  logic               i_eop,
    input  logic [DAT56_W-1:0] i_dat,
    output logic               o_rdy,
    output logic               o_res_vld,
    input  logic               i_res_rdy,
    output logic [CRC12_W-1:0] o_crc,
`ifdef IPPCRC_CRC12_CHK_EN
    input  logic [CRC12_W-1:0] i_crc_exp,
    output logic               o_crc_err,
`endif
    output logic               o_proto_err
);

    acc_state_t         r_state, w_state_n;
    logic [CRC12_W-1:0] r_crc, w_crc_n;
    logic               r_res_vld, w_res_vld_n;
    logic [CRC12_W-1:0] r_res_crc, w_res_crc_n;
    logic               r_perr, w_perr_n;
    logic               r_err, w_err_n;

    logic               w_acc;
    logic [CRC12_W-1:0] w_base;
    logic [CRC12_W-1:0] w_nxt;
    logic [CRC12_W-1:0] w_fin;
    logic               w_mis;

    assign o_rdy  = ~r_res_vld | i_res_rdy;
    assign w_acc  = i_vld & o_rdy;
    assign w_base = i_sop ? CRC_INIT : r_crc;
    assign w_fin  = w_nxt ^ CRC_XOROUT;

`ifdef IPPCRC_CRC12_CHK_EN
    assign w_mis     = (w_fin != i_crc_exp);
    assign o_crc_err = r_err;
`else
    assign w_mis = 1'b0;
`endif

    ippcrc_crc12_56b u_core (
        .ci (w_base),
        .di (i_dat),
        .co (w_nxt)
    );

    always_comb begin
        w_state_n   = r_state;
        w_crc_n     = r_crc;
        w_res_vld_n = r_res_vld & ~i_res_rdy;
        w_res_crc_n = r_res_crc;
        w_err_n     = r_err;
        w_perr_n    = 1'b0;
        if (w_acc) begin
            // An sop inside an open frame abandons it and restarts cleanly.
            if (i_sop || r_state == RUN) begin
                w_perr_n = i_sop & (r_state == RUN);
                if (i_eop) begin
                    w_state_n   = IDLE;
                    w_res_vld_n = 1'b1;
                    w_res_crc_n = w_fin;
                    w_err_n     = w_mis;
                end else begin
                    w_state_n = RUN;
                    w_crc_n   = w_nxt;
                end
            end else begin
                w_perr_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_crc     <= CRC_INIT;
            r_res_vld <= 1'b0;
            r_res_crc <= '0;
            r_err     <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_crc     <= w_crc_n;
            r_res_vld <= w_res_vld_n;
            r_res_crc <= w_res_crc_n;
            r_err     <= w_err_n;
            r_perr    <= w_perr_n;
        end
    end

    assign o_res_vld   = r_res_vld;
    assign o_crc       = r_res_crc;
    assign o_proto_err = r_perr;

`ifndef IPPCRC_CRC12_CHK_EN
    logic w_unused;
    assign w_unused = w_mis;
`endif

endmodule
